// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM encodings and counter-width helper for serial_adder
package serial_adder_pkg;

  // Controller states; encodings are fixed so other cells can decode them
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit-slice counter width: ceil(log2(width)), never narrower than one bit
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fa_bit.sv
// rtl/fa_bit.sv - combinational one-bit full-adder slice
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with valid/ready ports; SERIAL_ADDER_OVF_EN adds ovf
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             slice_s;
  logic             slice_co;
`ifdef SERIAL_ADDER_OVF_EN
  logic             carry_msb;
`endif

  fa_bit u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  assign sum  = sum_sr;
  assign cout = carry;
`ifdef SERIAL_ADDER_OVF_EN
  // Signed overflow: carry into the MSB slice disagrees with carry out of it
  assign ovf  = carry_msb ^ carry;
`endif

  // Controller, shift datapath and registered handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      carry_msb <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            carry    <= cin;
            cnt      <= '0;
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {slice_s, sum_sr[WIDTH-1:1]};
          carry  <= slice_co;
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
            carry_msb <= carry;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [10];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_add(input vec_t v, input string tag);
    int n;
    int lat;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, WIDTH + 1);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, v.sum});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, v.cout});
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, v.ovf});
`endif
    @(negedge clk);
    chk({tag, "_ready_after"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  logic [7:0] bb_a   [3] = '{8'h01, 8'h80, 8'hC3};
  logic [7:0] bb_b   [3] = '{8'h02, 8'h80, 8'h3D};
  logic [7:0] bb_sum [3] = '{8'h03, 8'h00, 8'h00};
  logic       bb_co  [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[8] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[9] = '{8'h22, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0};

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) run_add(vecs[i], $sformatf("vec%0d", i));

    // Backpressure with ignored operands while in DONE
    begin
      int lat;
      @(negedge clk);
      a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      chk("bp_latency", lat, WIDTH + 1);
      a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk($sformatf("bp_hold%0d", k), {22'd0, sum, cout, out_valid, in_ready, busy},
            {22'd0, 8'h46, 1'b0, 1'b1, 1'b0, 1'b1});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", {22'd0, sum, cout, out_valid, in_ready, busy},
          {22'd0, 8'h46, 1'b0, 1'b0, 1'b1, 1'b0});
    end

    // Asynchronous reset in the fourth SHIFT cycle
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", {21'd0, sum, cout, out_valid, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", {30'd0, in_ready, busy}, 32'd2);
    run_add(vecs[9], "post_rst");

    // Back-to-back with in_valid and out_ready held high
    begin
      int k_acc = 0;
      int k_res = 0;
      int cyc = 0;
      int acc_cyc [3];
      @(negedge clk);
      a = bb_a[0]; b = bb_b[0]; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      while (k_res < 3 && cyc < 200) begin
        if (in_ready && in_valid && k_acc < 3) begin
          acc_cyc[k_acc] = cyc;
          k_acc++;
        end
        if (out_valid) begin
          chk($sformatf("b2b_sum%0d", k_res), {23'd0, sum, cout},
              {23'd0, bb_sum[k_res], bb_co[k_res]});
          k_res++;
        end
        @(posedge clk);
        #1;
        if (k_acc < 3) begin
          a = bb_a[k_acc]; b = bb_b[k_acc];
        end else begin
          in_valid = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
      chk("b2b_results", k_res, 3);
      chk("b2b_gap01", acc_cyc[1] - acc_cyc[0], WIDTH + 2);
      chk("b2b_gap12", acc_cyc[2] - acc_cyc[1], WIDTH + 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
